// File: rtl/result_drain_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | result_drain_if : array-result capture and element stream bundle           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface result_drain_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int N            = 4,
    parameter int C_DATA_WIDTH = (2*DATA_WIDTH)+$clog2(N),
    parameter int OUT_WIDTH    = C_DATA_WIDTH,
    parameter int IDX_WIDTH    = $clog2(N*N)
);
    logic                                mm_valid_i;
    logic [N*N-1:0][C_DATA_WIDTH-1:0]    mm_c_i;
    logic                                mm_clear_o;
    logic                                out_valid_o;
    logic                                out_ready_i;
    logic [OUT_WIDTH-1:0]                out_data_o;
    logic [IDX_WIDTH-1:0]                out_index_o;
    logic                                out_last_o;
    logic                                out_sat_o;
    logic                                busy_o;

    // master is the drain block itself
    modport master (
        input  mm_valid_i, mm_c_i, out_ready_i,
        output mm_clear_o, out_valid_o, out_data_o, out_index_o,
               out_last_o, out_sat_o, busy_o
    );

    modport slave (
        output mm_valid_i, mm_c_i, out_ready_i,
        input  mm_clear_o, out_valid_o, out_data_o, out_index_o,
               out_last_o, out_sat_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/result_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | result_drain : snapshots the NxN array results, clears the array and       |
// | streams elements row-major. Optional clamp via RESULT_DRAIN_SAT_EN.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module result_drain #(
    parameter int DATA_WIDTH   = 8,
    parameter int N            = 4,
    parameter int C_DATA_WIDTH = (2*DATA_WIDTH)+$clog2(N),
    parameter int OUT_WIDTH    = C_DATA_WIDTH,
    parameter int IDX_WIDTH    = $clog2(N*N)
) (
    input  wire logic      clk,
    input  wire logic      reset_i,
    result_drain_if.master bus
);

    localparam logic [0:0]           C_ST_IDLE   = 1'b0;
    localparam logic [0:0]           C_ST_STREAM = 1'b1;
    localparam logic [IDX_WIDTH-1:0] C_LAST_IDX  = IDX_WIDTH'(N*N-1);

    logic [0:0]                       state_q, state_d;
    logic [IDX_WIDTH-1:0]             idx_q, idx_d;
    logic [N*N-1:0][C_DATA_WIDTH-1:0] buf_q, buf_d;
    logic                             mm_clear_q, mm_clear_d;

    logic                             w_streaming;
    logic                             w_capture;
    logic                             w_handshake;
    logic                             w_at_last;
    logic [C_DATA_WIDTH-1:0]          w_elem;
    logic [OUT_WIDTH-1:0]             w_conv;
    logic                             w_over;

    assign w_streaming = (state_q == C_ST_STREAM);
    assign w_capture   = (state_q == C_ST_IDLE) && bus.mm_valid_i;
    assign w_handshake = w_streaming && bus.out_ready_i;
    assign w_at_last   = (idx_q == C_LAST_IDX);
    assign w_elem      = buf_q[idx_q];

`ifdef RESULT_DRAIN_SAT_EN
    if (OUT_WIDTH < C_DATA_WIDTH) begin : g_sat
        localparam logic [C_DATA_WIDTH-1:0] C_MAX = C_DATA_WIDTH'({OUT_WIDTH{1'b1}});
        assign w_over = (w_elem > C_MAX);
        assign w_conv = w_over ? {OUT_WIDTH{1'b1}} : OUT_WIDTH'(w_elem);
    end else begin : g_wide
        assign w_over = 1'b0;
        assign w_conv = OUT_WIDTH'(w_elem);
    end
`else
    // size cast truncates when narrower and zero-extends when wider
    assign w_over = 1'b0;
    assign w_conv = OUT_WIDTH'(w_elem);
`endif

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q <= C_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_IDLE:   if (bus.mm_valid_i)            state_d = C_ST_STREAM;
            C_ST_STREAM: if (bus.out_ready_i && w_at_last) state_d = C_ST_IDLE;
            default:                                    state_d = C_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            idx_q      <= '0;
            buf_q      <= '0;
            mm_clear_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            buf_q      <= buf_d;
            mm_clear_q <= mm_clear_d;
        end
    end

    // buffer only loads in IDLE, so a held completion flag cannot disturb a stream
    always_comb begin
        idx_d      = idx_q;
        buf_d      = buf_q;
        mm_clear_d = 1'b0;
        if (w_capture) begin
            buf_d      = bus.mm_c_i;
            idx_d      = '0;
            mm_clear_d = 1'b1;
        end else if (w_handshake) begin
            idx_d = w_at_last ? '0 : idx_q + IDX_WIDTH'(1);
        end
    end

    always_comb begin
        bus.mm_clear_o  = mm_clear_q;
        bus.out_valid_o = w_streaming;
        bus.busy_o      = w_streaming;
        bus.out_index_o = w_streaming ? idx_q : '0;
        bus.out_last_o  = w_streaming && w_at_last;
        bus.out_data_o  = w_streaming ? w_conv : '0;
        bus.out_sat_o   = w_streaming && w_over;
    end

endmodule
`default_nettype wire
